rgmii_rx_gmii_adapter: RTL

Receive-direction adapter between the RGMII DDR input capture and the GMII MAC receive port. It takes per-cycle captured nibble pairs and control bits in the recovered RX clock domain and produces GMII bytes with a clock enable. At 1000M it is a registered pass-through. At 10/100M it performs nibble-to-byte reassembly, which is the receive-side mirror of the TX speed handling. It also decodes RGMII in-band link status from the inter-frame gap.

---
 rtl/rgmii_pkg.sv | 15 +
 rtl/rgmii_inband_status.sv | 47 ++++
 rtl/rgmii_rx_gmii_adapter.sv | 108 ++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared speed encodings, receive FSM states and in-band status layout
package rgmii_pkg;
    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_FLUSH} rx_state_t;

    // Field order matches the idle nibble: bit3 duplex, bits2:1 speed, bit0 link
    typedef struct packed {
        logic       duplex;
        logic [1:0] speed;
        logic       link;
    } inband_status_t;
endpackage

// File: rtl/rgmii_inband_status.sv
// rgmii_inband_status: samples RGMII in-band status during the inter-frame gap and debounces it
module rgmii_inband_status
    import rgmii_pkg::*;
#(
    parameter int STATUS_STABLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_q1,
    input  logic       in_ctl1,
    input  logic [3:0] in_q2,
    input  logic       in_ctl2,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic       status_valid
);
    localparam logic [3:0] STABLE = 4'(STATUS_STABLE);

    inband_status_t smp, cand;
    logic [3:0] cnt, cnt_nxt;
    logic sample;

    assign smp = inband_status_t'(in_q1);
    // Reserved speed code 11 is treated as a non-sample so it cannot disturb the debounce
    assign sample = !in_ctl1 && !in_ctl2 && in_q1 == in_q2 && smp.speed != 2'b11;
    assign cnt_nxt = (smp == cand && cnt != 4'd0) ? ((cnt == STABLE) ? cnt : cnt + 4'd1) : 4'd1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cand         <= '0;
            cnt          <= '0;
            link_up      <= 1'b0;
            link_speed   <= 2'b00;
            full_duplex  <= 1'b0;
            status_valid <= 1'b0;
        end else if (sample) begin
            cand <= smp;
            cnt  <= cnt_nxt;
            if (cnt_nxt == STABLE) begin
                link_up      <= smp.link;
                link_speed   <= smp.speed;
                full_duplex  <= smp.duplex;
                status_valid <= 1'b1;
            end
        end
endmodule

// File: rtl/rgmii_rx_gmii_adapter.sv
// rgmii_rx_gmii_adapter: captured RGMII nibbles to GMII bytes with clock enable, 10/100/1000M.
// Define RGMII_RX_INBAND_STATUS_EN to build the in-band link status decoder.
module rgmii_rx_gmii_adapter
    import rgmii_pkg::*;
#(
    parameter int STATUS_STABLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_q1,
    input  logic       in_ctl1,
    input  logic [3:0] in_q2,
    input  logic       in_ctl2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_clk_en,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic       status_valid
);
    rx_state_t  state;
    logic [1:0] act_speed;
    logic [3:0] low;
    logic       low_er, phase, nib_er;

    assign nib_er = in_ctl1 ^ in_ctl2;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state          <= ST_IDLE;
            act_speed      <= SPEED_10M;
            low            <= 4'h0;
            low_er         <= 1'b0;
            phase          <= 1'b0;
            gmii_rxd       <= 8'h00;
            gmii_rx_dv     <= 1'b0;
            gmii_rx_er     <= 1'b0;
            gmii_rx_clk_en <= 1'b0;
        end else begin
            // Speed only changes between frames so a frame is never split across modes
            if (state == ST_IDLE && !in_ctl1) act_speed <= speed;
            if (act_speed[1]) begin
                state          <= ST_IDLE;
                gmii_rxd       <= {in_q2, in_q1};
                gmii_rx_dv     <= in_ctl1;
                gmii_rx_er     <= nib_er;
                gmii_rx_clk_en <= 1'b1;
            end else begin
                gmii_rx_clk_en <= 1'b0;
                case (state)
                    ST_IDLE, ST_FLUSH:
                        if (in_ctl1) begin
                            low    <= in_q1;
                            low_er <= nib_er;
                            phase  <= 1'b0;
                            state  <= ST_HIGH;
                        end else begin
                            phase          <= ~phase;
                            state          <= ST_IDLE;
                            gmii_rx_clk_en <= phase;
                            if (phase) begin
                                gmii_rxd   <= 8'h00;
                                gmii_rx_dv <= 1'b0;
                                gmii_rx_er <= 1'b0;
                            end
                        end
                    ST_HIGH: begin
                        gmii_rxd       <= in_ctl1 ? {in_q1, low} : {4'h0, low};
                        gmii_rx_dv     <= 1'b1;
                        gmii_rx_er     <= in_ctl1 ? (low_er | nib_er) : 1'b1;
                        gmii_rx_clk_en <= 1'b1;
                        state          <= in_ctl1 ? ST_LOW : ST_FLUSH;
                    end
                    ST_LOW:
                        if (in_ctl1) begin
                            low    <= in_q1;
                            low_er <= nib_er;
                            state  <= ST_HIGH;
                        end else begin
                            state <= ST_IDLE;
                        end
                endcase
            end
        end

`ifdef RGMII_RX_INBAND_STATUS_EN
    rgmii_inband_status #(.STATUS_STABLE(STATUS_STABLE)) u_status (
        .clk          (clk),
        .rst          (rst),
        .in_q1        (in_q1),
        .in_ctl1      (in_ctl1),
        .in_q2        (in_q2),
        .in_ctl2      (in_ctl2),
        .link_up      (link_up),
        .link_speed   (link_speed),
        .full_duplex  (full_duplex),
        .status_valid (status_valid)
    );
`else
    assign link_up      = 1'b0;
    assign link_speed   = 2'b00;
    assign full_duplex  = 1'b0;
    assign status_valid = 1'b0;
`endif
endmodule
